regfile_scoreboard: RTL and testbench

//   Parametrised multi-read-port integer register file for the next-generation (pipelined) core.

---
 rtl/regfile_scoreboard.sv | 92 +++++++++
 tb/tb_regfile_scoreboard.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with per-register busy bits,
// optional same-cycle write forwarding and a hard-wired zero register.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [XLEN-1:0]      wd,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 flush,
    output logic                 busy_any
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr_ok;

    assign wr_ok = we && !(ZERO_REG != 0 && wa == '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wa] = wd;
        end
    end

    // A fresh reservation outranks both flush and writeback.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (rsv_en && rsv_addr == AW'(r)
                && !(ZERO_REG != 0 && r == 0)) begin
                busy_d[r] = 1'b1;
            end else if (flush) begin
                busy_d[r] = 1'b0;
            end else if (we && wa == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[p*AW +: AW];

        always_comb begin
            d = mem_q[a];
            b = busy_q[a];
            if (ZERO_REG != 0 && a == '0) begin
                d = '0;
                b = 1'b0;
            end else if (BYPASS != 0 && we && wa == a) begin
                d = wd;
                b = 1'b0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = d;
        assign rd_busy[p]              = b;
    end

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard-driven bench for regfile_scoreboard: default instance plus
// a 16-entry, 3-port, no-bypass instance.
module tb_regfile_scoreboard;

    typedef struct {
        logic [31:0] d;
        logic        b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default instance: NREGS=32 AW=5 NRD=2 BYPASS=1
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        a_rsv_en;
    logic [4:0]  a_rsv_addr;
    logic        a_flush;
    logic        a_busy_any;

    regfile_scoreboard u_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .rd_busy  (a_rd_busy),
        .we       (a_we),
        .wa       (a_wa),
        .wd       (a_wd),
        .rsv_en   (a_rsv_en),
        .rsv_addr (a_rsv_addr),
        .flush    (a_flush),
        .busy_any (a_busy_any)
    );

    // NREGS=16 AW=4 NRD=3 BYPASS=0
    logic [11:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_we;
    logic [3:0]  b_wa;
    logic [31:0] b_wd;
    logic        b_rsv_en;
    logic [3:0]  b_rsv_addr;
    logic        b_flush;
    logic        b_busy_any;

    regfile_scoreboard #(
        .XLEN     (32),
        .NREGS    (16),
        .NRD      (3),
        .BYPASS   (0),
        .ZERO_REG (1)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_busy  (b_rd_busy),
        .we       (b_we),
        .wa       (b_wa),
        .wd       (b_wd),
        .rsv_en   (b_rsv_en),
        .rsv_addr (b_rsv_addr),
        .flush    (b_flush),
        .busy_any (b_busy_any)
    );

    task automatic push(input logic [31:0] d, input logic b);
        exp_t e;
        e.d = d;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic idle_a();
        a_we     = 1'b0;
        a_wa     = '0;
        a_wd     = '0;
        a_rsv_en = 1'b0;
        a_rsv_addr = '0;
        a_flush  = 1'b0;
    endtask

    task automatic idle_b();
        b_we     = 1'b0;
        b_wa     = '0;
        b_wd     = '0;
        b_rsv_en = 1'b0;
        b_rsv_addr = '0;
        b_flush  = 1'b0;
    endtask

    task automatic set_a(input logic [4:0] p0, input logic [4:0] p1);
        a_rd_addr = {p1, p0};
    endtask

    task automatic test_reset();
        exp_t e;
        idle_a();
        idle_b();
        set_a(5'd3, 5'd31);
        b_rd_addr = {4'd15, 4'd7, 4'd1};
        rst = 1'b0;
        #2;
        push(32'h0, 1'b0);
        push(32'h0, 1'b0);
        push(32'h0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL reset_p0 got %h/%b want %h/%b",
                     a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL reset_p1 got %h/%b want %h/%b",
                     a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b || b_busy_any !== e.b
            || b_rd_data !== 96'h0) begin
            fails++;
            $display("FAIL reset_any got %b %b %h want 0",
                     a_busy_any, b_busy_any, b_rd_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        exp_t e;
        @(negedge clk);
        a_we = 1'b1;
        a_wa = 5'd5;
        a_wd = 32'hDEADBEEF;
        set_a(5'd6, 5'd5);
        push(32'hDEADBEEF, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL wr_bypass got %h/%b want %h/%b",
                     a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
        end
        @(negedge clk);
        idle_a();
        set_a(5'd5, 5'd6);
        push(32'hDEADBEEF, 1'b0);
        push(32'h0, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL wr_read got %h/%b want %h/%b",
                     a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d) begin
            fails++;
            $display("FAIL wr_other got %h want %h",
                     a_rd_data[63:32], e.d);
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        @(negedge clk);
        a_we = 1'b1;
        a_wa = 5'd0;
        a_wd = 32'h12345678;
        set_a(5'd5, 5'd0);
        push(32'h0, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL zero_nobypass got %h/%b want %h/%b",
                     a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
        end
        @(negedge clk);
        idle_a();
        a_rsv_en = 1'b1;
        a_rsv_addr = 5'd0;
        @(negedge clk);
        idle_a();
        set_a(5'd0, 5'd0);
        push(32'h0, 1'b0);
        push(32'h0, 1'b0);
        push(32'h0, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL zero_p0 got %h/%b want %h/%b",
                     a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL zero_p1 got %h/%b want %h/%b",
                     a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b) begin
            fails++;
            $display("FAIL zero_busy_any got %b want %b",
                     a_busy_any, e.b);
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        @(negedge clk);
        a_rsv_en = 1'b1;
        a_rsv_addr = 5'd7;
        @(negedge clk);
        a_rsv_addr = 5'd7;
        set_a(5'd7, 5'd7);
        push(32'h0, 1'b1);
        push(32'h0, 1'b1);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL sb_busy got %h/%b want %h/%b",
                     a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL sb_busy_any got %b/%b want %b",
                     a_busy_any, a_rd_busy[1], e.b);
        end
        @(negedge clk);
        idle_a();
        a_we = 1'b1;
        a_wa = 5'd7;
        a_wd = 32'h0000_0077;
        push(32'h77, 1'b0);
        push(32'h0, 1'b1);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL sb_wb_bypass got %h/%b want %h/%b",
                     a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b) begin
            fails++;
            $display("FAIL sb_any_pre got %b want %b", a_busy_any, e.b);
        end
        @(negedge clk);
        idle_a();
        push(32'h77, 1'b0);
        push(32'h0, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL sb_cleared got %h/%b want %h/%b",
                     a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b) begin
            fails++;
            $display("FAIL sb_any_post got %b want %b", a_busy_any, e.b);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        @(negedge clk);
        a_rsv_en = 1'b1;
        a_rsv_addr = 5'd10;
        @(negedge clk);
        a_rsv_addr = 5'd9;
        a_we = 1'b1;
        a_wa = 5'd9;
        a_wd = 32'h0000_00A5;
        a_flush = 1'b1;
        @(negedge clk);
        idle_a();
        set_a(5'd9, 5'd10);
        push(32'hA5, 1'b1);
        push(32'h0, 1'b0);
        push(32'h0, 1'b1);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL sim_r9 got %h/%b want %h/%b",
                     a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL sim_r10 got %h/%b want %h/%b",
                     a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b) begin
            fails++;
            $display("FAIL sim_any got %b want %b", a_busy_any, e.b);
        end
        @(negedge clk);
        a_flush = 1'b1;
        @(negedge clk);
        idle_a();
        push(32'h0, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL flush_any got %b/%b want %b",
                     a_busy_any, a_rd_busy[0], e.b);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] vals [8];
        for (int i = 0; i < 8; i++) begin
            vals[i] = $urandom;
        end
        // twice-reserved r12 must clear on a single write
        @(negedge clk);
        a_rsv_en = 1'b1;
        a_rsv_addr = 5'd12;
        @(negedge clk);
        @(negedge clk);
        idle_a();
        for (int i = 0; i < 8; i++) begin
            a_we = 1'b1;
            a_wa = 5'(12 + i);
            a_wd = vals[i];
            @(negedge clk);
        end
        idle_a();
        for (int i = 0; i < 8; i += 2) begin
            set_a(5'(12 + i), 5'(13 + i));
            push(vals[i], 1'b0);
            push(vals[i+1], 1'b0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
                fails++;
                $display("FAIL b2b_r%0d got %h/%b want %h/%b", 12 + i,
                         a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
            end
            e = exp_q.pop_front();
            checks++;
            if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
                fails++;
                $display("FAIL b2b_r%0d got %h/%b want %h/%b", 13 + i,
                         a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
            end
            @(negedge clk);
        end
        push(32'h0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b) begin
            fails++;
            $display("FAIL b2b_any got %b want %b", a_busy_any, e.b);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        a_rsv_en = 1'b1;
        a_rsv_addr = 5'd4;
        a_we = 1'b1;
        a_wa = 5'd3;
        a_wd = 32'h1111_2222;
        @(negedge clk);
        idle_a();
        a_we = 1'b1;
        a_wa = 5'd20;
        a_wd = 32'hCAFE_F00D;
        set_a(5'd3, 5'd4);
        #2;
        rst = 1'b0;
        a_we = 1'b0;
        #1;
        push(32'h0, 1'b0);
        push(32'h0, 1'b0);
        push(32'h0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d || a_rd_busy[0] !== e.b) begin
            fails++;
            $display("FAIL arst_r3 got %h/%b want %h/%b",
                     a_rd_data[31:0], a_rd_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[63:32] !== e.d || a_rd_busy[1] !== e.b) begin
            fails++;
            $display("FAIL arst_r4 got %h/%b want %h/%b",
                     a_rd_data[63:32], a_rd_busy[1], e.d, e.b);
        end
        e = exp_q.pop_front();
        checks++;
        if (a_busy_any !== e.b) begin
            fails++;
            $display("FAIL arst_any got %b want %b", a_busy_any, e.b);
        end
        @(negedge clk);
        rst = 1'b1;
        set_a(5'd20, 5'd3);
        @(negedge clk);
        push(32'h0, 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (a_rd_data[31:0] !== e.d) begin
            fails++;
            $display("FAIL arst_r20 got %h want %h", a_rd_data[31:0], e.d);
        end
    endtask

    task automatic test_params();
        exp_t e;
        @(negedge clk);
        idle_b();
        b_we = 1'b1;
        b_wa = 4'd15;
        b_wd = 32'h1111_1111;
        @(negedge clk);
        b_wd = 32'h2222_2222;
        b_rd_addr = {4'd15, 4'd15, 4'd15};
        for (int p = 0; p < 3; p++) push(32'h1111_1111, 1'b0);
        #1;
        for (int p = 0; p < 3; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (b_rd_data[p*32 +: 32] !== e.d || b_rd_busy[p] !== e.b) begin
                fails++;
                $display("FAIL nobypass_p%0d got %h/%b want %h/%b", p,
                         b_rd_data[p*32 +: 32], b_rd_busy[p], e.d, e.b);
            end
        end
        @(negedge clk);
        idle_b();
        for (int p = 0; p < 3; p++) push(32'h2222_2222, 1'b0);
        #1;
        for (int p = 0; p < 3; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (b_rd_data[p*32 +: 32] !== e.d || b_rd_busy[p] !== e.b) begin
                fails++;
                $display("FAIL p3_read_p%0d got %h/%b want %h/%b", p,
                         b_rd_data[p*32 +: 32], b_rd_busy[p], e.d, e.b);
            end
        end
    endtask

    initial begin
        idle_a();
        idle_b();
        set_a(5'd0, 5'd0);
        b_rd_addr = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        test_params();
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
